axis_frame_receiver: RTL and testbench

Receive-side counterpart of the radar chain's tlast generator. It consumes an AXI-Stream of FRAME_LEN-sample frames delimited by tlast (the chirp/FFT sample stream) and re-derives per-beat bin index, start-/end-of-frame flags and a good-frame count. It polices tlast placement, flags early or missing tlast, and resynchronises to the next tlast. It sits between the FFT/stream output and the downstream range-profile and classification logic.

---
 rtl/axis_frame_receiver.sv | 136 +++++++++++++
 tb/tb_axis_frame_receiver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_receiver.sv
// Frame receiver: re-derives bin index, sof/eof and good-frame count from a tlast-delimited AXI-Stream, polices tlast.
// Latency: one cycle (beat accepted at edge N is on m_* after edge N); 1 beat/cycle sustained.
// Backpressure: one-deep output register; s_axis_tready = !m_valid | m_ready in SYNC, always 1 in HUNT (beats discarded).
// Optional: define RX_ERR_CNT_EN to add the 16-bit saturating err_cnt port.
module axis_frame_receiver #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 128,
  parameter int BIN_W     = 7,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BIN_W-1:0]  m_bin,
  output logic              m_sof,
  output logic              m_eof,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_early,
  output logic              err_late,
  output logic              in_sync
`ifdef RX_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  typedef enum logic {SYNC = 1'b0, HUNT = 1'b1} state_t;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             accept;
  logic             sync_acc;
  logic             last_bin;

  // HUNT never blocks the source; SYNC only blocks when the output register is full and stalled.
  assign s_axis_tready = (state_q == HUNT) | ~m_valid | m_ready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign sync_acc      = accept & (state_q == SYNC);
  assign last_bin      = (bin_q == LAST_BIN);
  assign in_sync       = (state_q == SYNC);

  // State and bin counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
    end
  end

  // Next state / next bin: any frame end (good, early or missing tlast) restarts at bin 0
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    case (state_q)
      SYNC: begin
        if (accept) begin
          if (last_bin || s_axis_tlast) begin
            bin_d = '0;
          end else begin
            bin_d = bin_q + BIN_W'(1);
          end
          if (last_bin && !s_axis_tlast) begin
            state_d = HUNT;
          end
        end
      end
      HUNT: begin
        if (accept && s_axis_tlast) begin
          state_d = SYNC;
          bin_d   = '0;
        end
      end
      default: begin
        state_d = SYNC;
        bin_d   = '0;
      end
    endcase
  end

  // Output register: load on a SYNC accept, otherwise drain when downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_bin   <= '0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (sync_acc) begin
      m_valid <= 1'b1;
      m_data  <= s_axis_tdata;
      m_bin   <= bin_q;
      m_sof   <= (bin_q == '0);
      m_eof   <= s_axis_tlast | last_bin;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Error pulses and good-frame counter, decided on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_early <= 1'b0;
      err_late  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      err_early <= sync_acc & ~last_bin & s_axis_tlast;
      err_late  <= sync_acc & last_bin & ~s_axis_tlast;
      if (sync_acc && last_bin && s_axis_tlast) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

`ifdef RX_ERR_CNT_EN
  // Saturating error counter, bumped once per error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((err_early || err_late) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_receiver.sv
module tb_axis_frame_receiver;

  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 128;
  localparam int BIN_W     = 7;
  localparam int FCNT_W    = 16;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [BIN_W-1:0]  m_bin;
  logic              m_sof;
  logic              m_eof;
  logic [FCNT_W-1:0] frame_cnt;
  logic              err_early;
  logic              err_late;
  logic              in_sync;
`ifdef RX_ERR_CNT_EN
  logic [15:0]       err_cnt;
`endif

  axis_frame_receiver #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .BIN_W(BIN_W), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_bin(m_bin), .m_sof(m_sof), .m_eof(m_eof),
    .frame_cnt(frame_cnt), .err_early(err_early), .err_late(err_late),
    .in_sync(in_sync)
`ifdef RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [BIN_W-1:0]  b;
    logic              sof;
    logic              eof;
    logic              ee;
    logic              el;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   stall_cnt   = 0;
  bit   rand_ready  = 0;

  // reference view of the receiver, advanced once per accepted input beat
  bit   ref_sync = 1;
  int   ref_bin  = 0;
  int   exp_err  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int f, input int b);
    return {8'hA5, 8'(f), 16'(b)};
  endfunction

  // Push the expected output for an accepted beat
  task automatic ref_accept(input logic [DATA_W-1:0] d, input logic last);
    exp_t e;
    if (ref_sync) begin
      e.d   = d;
      e.b   = BIN_W'(ref_bin);
      e.sof = (ref_bin == 0);
      e.eof = last || (ref_bin == FRAME_LEN - 1);
      e.ee  = last && (ref_bin < FRAME_LEN - 1);
      e.el  = !last && (ref_bin == FRAME_LEN - 1);
      sbq.push_back(e);
      if ((e.ee || e.el) && exp_err < 16'hFFFF) exp_err++;
      if (e.el) ref_sync = 0;
      ref_bin = e.eof ? 0 : ref_bin + 1;
    end else if (last) begin
      ref_sync = 1;
      ref_bin  = 0;
    end
  endtask

  // Drive one beat and hold it until accepted; returns 1 ns after the accepting edge
  task automatic send(input logic [DATA_W-1:0] d, input logic last);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) begin
        done = 1;
        ref_accept(d, last);
      end else begin
        stall_cnt++;
      end
      n++;
      @(posedge clk);
      #1;
      if (!done && n > 200) begin
        check("send_timeout", 64'(s_axis_tready), 64'd1);
        done = 1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", 64'(sbq.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_bin", 64'(m_bin), 64'd0);
    check("rst_m_sof", 64'(m_sof), 64'd0);
    check("rst_m_eof", 64'(m_eof), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_err_early", 64'(err_early), 64'd0);
    check("rst_err_late", 64'(err_late), 64'd0);
    check("rst_in_sync", 64'(in_sync), 64'd1);
    check("rst_tready", 64'(s_axis_tready), 64'd1);
`ifdef RX_ERR_CNT_EN
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
  endtask

  task automatic check_err_cnt();
`ifdef RX_ERR_CNT_EN
    check("err_cnt", 64'(err_cnt), 64'(exp_err));
`endif
  endtask

  // Downstream ready: constant 1 or 50% random, changed just after each edge
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every presented output against the scoreboard head
  initial begin
    exp_t e;
    bit   prev_stall;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (m_valid) begin
          if (sbq.size() == 0) begin
            check("unexpected_m_valid", 64'(m_valid), 64'd0);
          end else begin
            e = sbq[0];
            check("m_data", 64'(m_data), 64'(e.d));
            check("m_bin", 64'(m_bin), 64'(e.b));
            check("m_sof", 64'(m_sof), 64'(e.sof));
            check("m_eof", 64'(m_eof), 64'(e.eof));
            // error pulses belong only to the first cycle a beat is presented
            check("err_early", 64'(err_early), prev_stall ? 64'd0 : 64'(e.ee));
            check("err_late", 64'(err_late), prev_stall ? 64'd0 : 64'(e.el));
            if (in_sync && !m_ready) check("tready_while_full", 64'(s_axis_tready), 64'd0);
            if (m_ready) void'(sbq.pop_front());
          end
        end else begin
          check("err_early_idle", 64'(err_early), 64'd0);
          check("err_late_idle", 64'(err_late), 64'd0);
        end
        prev_stall = m_valid && !m_ready;
      end
    end
  end

  initial begin
    rst_n         = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check_reset_values();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // three good frames, full throughput
    stall_cnt = 0;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < FRAME_LEN; b++)
        send(mk(f, b), b == FRAME_LEN - 1);
    drain();
    check("good_frame_cnt", 64'(frame_cnt), 64'd3);
    check("full_rate_no_stalls", 64'(stall_cnt), 64'd0);
    check_err_cnt();

    // early tlast on bin 63, then a good frame
    for (int b = 0; b < 64; b++) begin
      send(mk(3, b), b == 63);
      if (b == 63) begin
        check("early_pulse", 64'(err_early), 64'd1);
        check("early_m_bin", 64'(m_bin), 64'd63);
        check("early_m_eof", 64'(m_eof), 64'd1);
      end
    end
    for (int b = 0; b < FRAME_LEN; b++)
      send(mk(4, b), b == FRAME_LEN - 1);
    drain();
    check("frame_cnt_after_early", 64'(frame_cnt), 64'd4);
    check_err_cnt();

    // missing tlast on bin 127, five hunted beats, then a good frame
    for (int b = 0; b < FRAME_LEN; b++) send(mk(5, b), 1'b0);
    check("late_pulse", 64'(err_late), 64'd1);
    check("late_m_bin", 64'(m_bin), 64'd127);
    check("late_in_sync", 64'(in_sync), 64'd0);
    for (int b = 0; b < 5; b++) send(mk(6, b), b == 4);
    check("resync_in_sync", 64'(in_sync), 64'd1);
    for (int b = 0; b < FRAME_LEN; b++)
      send(mk(7, b), b == FRAME_LEN - 1);
    drain();
    check("frame_cnt_after_late", 64'(frame_cnt), 64'd5);
    check_err_cnt();

    // four good frames under random backpressure
    rand_ready = 1;
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < FRAME_LEN; b++)
        send(mk(8 + f, b), b == FRAME_LEN - 1);
    rand_ready = 0;
    drain();
    check("frame_cnt_random_ready", 64'(frame_cnt), 64'd9);

    // reset in the middle of a frame at bin 40
    for (int b = 0; b < 40; b++) send(mk(12, b), 1'b0);
    drain();
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    sbq.delete();
    ref_sync = 1;
    ref_bin  = 0;
    exp_err  = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int b = 0; b < FRAME_LEN; b++)
      send(mk(13, b), b == FRAME_LEN - 1);
    drain();
    check("frame_cnt_after_reset", 64'(frame_cnt), 64'd1);

`ifdef RX_ERR_CNT_EN
    // single-beat early frames drive the error counter into saturation
    for (int i = 0; i < 65600; i++) send(DATA_W'(i), 1'b1);
    drain();
    check("err_cnt_saturated", 64'(err_cnt), 64'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
